// File: rtl/sram_device_model.sv
// Cycle-accurate responder for the 16-bit external SRAM pin interface.
// Byte-masked writes, 0..3 cycle read latency, tri-state data bus, access counters and sticky error flags.
module sram_device_model #(
  parameter int          DEPTH_LOG2   = 12,
  parameter int          READ_LATENCY = 0,
  parameter logic [15:0] INIT_VALUE   = 16'h0000,
  parameter logic [15:0] OOB_DATA     = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        oob_error,
  output logic        contention
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } rd_slot_t;

  // Initial contents only; reset deliberately leaves memory alone.
  logic [15:0] mem_q [DEPTH] = '{default: INIT_VALUE};

  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_cyc, rd_cyc;
  logic [15:0]           rd_word;

  logic                  last_vld;
  logic                  drv_en;
  logic [15:0]           drv_data;
  logic                  drv_ub_n, drv_lb_n;

  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        oob_q, oob_d;
  logic        con_q, con_d;

  generate
    if (DEPTH_LOG2 < 18) begin : g_decode
      assign in_range = ~|SRAM_ADDR[17:DEPTH_LOG2];
    end else begin : g_decode_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign idx     = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign wr_cyc  = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_cyc  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
  assign rd_word = in_range ? mem_q[idx] : OOB_DATA;

  always_ff @(posedge clk) begin
    if (!rst && wr_cyc && in_range) begin
      if (!SRAM_LB_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      assign last_vld = 1'b0;
      assign drv_en   = rd_cyc && !rst;
      assign drv_data = rd_word;
      assign drv_ub_n = SRAM_UB_N;
      assign drv_lb_n = SRAM_LB_N;
    end else begin : g_pipe_rd
      logic [READ_LATENCY:1] vld_pipe_q;
      rd_slot_t              slot_q [1:READ_LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe_q <= '0;
        end else begin
          vld_pipe_q[1] <= rd_cyc;
          for (int i = 2; i <= READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end

      // Payload needs no reset: it is only ever qualified by vld_pipe_q.
      always_ff @(posedge clk) begin
        slot_q[1] <= '{data: rd_word, ub_n: SRAM_UB_N, lb_n: SRAM_LB_N};
        for (int i = 2; i <= READ_LATENCY; i++) slot_q[i] <= slot_q[i-1];
      end

      assign last_vld = vld_pipe_q[READ_LATENCY];
      assign drv_en   = last_vld && !rst && rd_cyc;
      assign drv_data = slot_q[READ_LATENCY].data;
      assign drv_ub_n = slot_q[READ_LATENCY].ub_n;
      assign drv_lb_n = slot_q[READ_LATENCY].lb_n;
    end
  endgenerate

  // drv_en already requires WE_N=1, so a colliding write always wins the bus.
  assign SRAM_DQ[15:8] = (drv_en && !drv_ub_n) ? drv_data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drv_en && !drv_lb_n) ? drv_data[7:0]  : 8'hzz;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    oob_d    = oob_q;
    con_d    = con_q;
    if (wr_cyc && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    if (rd_cyc && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if ((wr_cyc || rd_cyc) && !in_range) oob_d = 1'b1;
    if (last_vld && !SRAM_WE_N) con_d = 1'b1;
    if (rst) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      oob_d    = 1'b0;
      con_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wr_cnt_q <= wr_cnt_d;
    rd_cnt_q <= rd_cnt_d;
    oob_q    <= oob_d;
    con_q    <= con_d;
  end

  assign wr_count   = wr_cnt_q;
  assign rd_count   = rd_cnt_q;
  assign oob_error  = oob_q;
  assign contention = con_q;

endmodule
